// File: rtl/flag_condition_unit.sv
// Latches V/Z/S/C status flags and evaluates 4-bit condition codes for the sequencer.
// Optional sticky overflow flag enabled by defining STICKY_OVF_EN.
module flag_condition_unit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic             V_in,
    input  logic             Z_in,
    input  logic             S_in,
    input  logic             C_in,
    input  logic             cond_valid,
    input  logic [3:0]       cond_code,
    output logic             cond_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             cond_true,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] true_cnt,
    input  logic             cnt_clr,
    output logic             sticky_v,
    input  logic             sticky_clr
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [3:0]       flags_d;
    logic [3:0]       eff;
    logic             eval;
    logic             accept;
    logic             cond_true_q, cond_true_d;
    logic [CNT_W-1:0] true_cnt_q, true_cnt_d;

    // Forward freshly written flags so a same-cycle request sees them
    assign eff    = flag_we ? {V_in, Z_in, S_in, C_in} : flags_q;
    assign accept = (state_q == StIdle) && cond_valid;

    always_comb begin
        logic v, z, s, c;
        {v, z, s, c} = eff;
        eval = 1'b0;
        unique case (cond_code)
            4'h0: eval = z;
            4'h1: eval = ~z;
            4'h2: eval = c;
            4'h3: eval = ~c;
            4'h4: eval = s;
            4'h5: eval = ~s;
            4'h6: eval = v;
            4'h7: eval = ~v;
            4'h8: eval = c & ~z;
            4'h9: eval = ~c | z;
            4'hA: eval = (s == v);
            4'hB: eval = (s != v);
            4'hC: eval = ~z & (s == v);
            4'hD: eval = z | (s != v);
            4'hE: eval = 1'b1;
            4'hF: eval = 1'b0;
            default: eval = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cond_true_d = cond_true_q;
        flags_d     = flag_we ? {V_in, Z_in, S_in, C_in} : flags_q;
        true_cnt_d  = true_cnt_q;
        case (state_q)
            StIdle: begin
                if (cond_valid) begin
                    cond_true_d = eval;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (cnt_clr) begin
            true_cnt_d = '0;
        end else if (accept && eval && (true_cnt_q != CntMax)) begin
            true_cnt_d = true_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            flags_q     <= 4'b0000;
            cond_true_q <= 1'b0;
            true_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cond_true_q <= cond_true_d;
            true_cnt_q  <= true_cnt_d;
        end
    end

    // Ready is held low while reset is asserted
    assign cond_ready = (state_q == StIdle) && rst_n;
    assign res_valid  = (state_q == StHold);
    assign cond_true  = cond_true_q;
    assign true_cnt   = true_cnt_q;

`ifdef STICKY_OVF_EN
    logic sticky_q;

    // A set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (flag_we && V_in) begin
            sticky_q <= 1'b1;
        end else if (sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_v = sticky_q;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign sticky_v          = 1'b0;
`endif

endmodule

// File: tb/tb_flag_condition_unit.sv
// Directed, table-driven bench for flag_condition_unit plus hand-written multi-cycle sequences.
module tb_flag_condition_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_we, V_in, Z_in, S_in, C_in;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       res_ready, cnt_clr, sticky_clr;

    logic       cond_ready, res_valid, cond_true, sticky_v;
    logic [3:0] flags_q;
    logic [7:0] true_cnt;

    logic       cond_ready2, res_valid2, cond_true2, sticky_v2;
    logic [3:0] flags_q2;
    logic [1:0] true_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_cnt2 = 0;

    always #5 clk = ~clk;

    flag_condition_unit dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .V_in(V_in), .Z_in(Z_in), .S_in(S_in), .C_in(C_in),
        .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready),
        .res_valid(res_valid), .res_ready(res_ready), .cond_true(cond_true),
        .flags_q(flags_q), .true_cnt(true_cnt), .cnt_clr(cnt_clr),
        .sticky_v(sticky_v), .sticky_clr(sticky_clr)
    );

    flag_condition_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .V_in(V_in), .Z_in(Z_in), .S_in(S_in), .C_in(C_in),
        .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready2),
        .res_valid(res_valid2), .res_ready(res_ready), .cond_true(cond_true2),
        .flags_q(flags_q2), .true_cnt(true_cnt2), .cnt_clr(cnt_clr),
        .sticky_v(sticky_v2), .sticky_clr(sticky_clr)
    );

    typedef struct {
        logic [3:0] flags;
        logic [3:0] code;
        logic       exp;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {V_in, Z_in, S_in, C_in} = f;
    endtask

    // Reference counter update for an accepted request
    task automatic model_accept(input logic exp);
        if (exp && exp_cnt != 255) exp_cnt++;
        if (exp && exp_cnt2 != 3) exp_cnt2++;
    endtask

    // One full request/response transaction; optionally writes flags in the accept cycle
    task automatic issue(input logic [3:0] f, input logic we, input logic [3:0] code,
                         input logic exp, input string nm);
        flag_we = we;
        set_flags(f);
        cond_valid = 1'b1;
        cond_code = code;
        step();
        flag_we = 1'b0;
        cond_valid = 1'b0;
        model_accept(exp);
        check({nm, " res_valid"}, int'(res_valid), 1);
        check({nm, " cond_true"}, int'(cond_true), int'(exp));
        check({nm, " true_cnt"}, int'(true_cnt), exp_cnt);
        if (we) check({nm, " flags_q"}, int'(flags_q), int'(f));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({nm, " cond_ready"}, int'(cond_ready), 1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{4'b0100, 4'h0, 1'b1}, '{4'b0000, 4'h0, 1'b0}, '{4'b0100, 4'h1, 1'b0},
            '{4'b0001, 4'h2, 1'b1}, '{4'b0001, 4'h3, 1'b0}, '{4'b0010, 4'h4, 1'b1},
            '{4'b0010, 4'h5, 1'b0}, '{4'b1000, 4'h6, 1'b1}, '{4'b0000, 4'h7, 1'b1},
            '{4'b0001, 4'h8, 1'b1}, '{4'b0101, 4'h8, 1'b0}, '{4'b0001, 4'h9, 1'b0},
            '{4'b0000, 4'h9, 1'b1}, '{4'b1010, 4'hA, 1'b1}, '{4'b1010, 4'hB, 1'b0},
            '{4'b0010, 4'hB, 1'b1}, '{4'b0000, 4'hC, 1'b1}, '{4'b0100, 4'hC, 1'b0},
            '{4'b1000, 4'hD, 1'b1}, '{4'b0010, 4'hD, 1'b1}, '{4'b1010, 4'hD, 1'b0},
            '{4'b0000, 4'hE, 1'b1}, '{4'b1111, 4'hF, 1'b0}
        };

        rst_n = 1'b0;
        flag_we = 1'b0; set_flags(4'b0000);
        cond_valid = 1'b0; cond_code = 4'h0;
        res_ready = 1'b0; cnt_clr = 1'b0; sticky_clr = 1'b0;
        #12;
        check("reset flags_q", int'(flags_q), 0);
        check("reset res_valid", int'(res_valid), 0);
        check("reset cond_true", int'(cond_true), 0);
        check("reset true_cnt", int'(true_cnt), 0);
        check("reset sticky_v", int'(sticky_v), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready after reset", int'(cond_ready), 1);
        step();

        // Latched flags, then request without a write
        flag_we = 1'b1; set_flags(4'b0100);
        step();
        flag_we = 1'b0; set_flags(4'b0000);
        check("latch flags_q", int'(flags_q), 4);
        issue(4'b0000, 1'b0, 4'h0, 1'b1, "eq latched");
        check("eq latched cnt", int'(true_cnt), 1);

        // Same-cycle write forwards Z=0 over the stale Z=1
        issue(4'b0000, 1'b1, 4'h0, 1'b0, "eq forward");

        foreach (vecs[i]) begin
            issue(vecs[i].flags, 1'b1, vecs[i].code, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Stall in HOLD: result and ready stable, flag write does not disturb the result
        flag_we = 1'b1; set_flags(4'b1010);
        cond_valid = 1'b1; cond_code = 4'hA;
        step();
        model_accept(1'b1);
        cond_code = 4'hB;
        for (int k = 0; k < 3; k++) begin
            flag_we = (k == 0);
            set_flags(4'b1000);
            check($sformatf("hold%0d cond_ready", k), int'(cond_ready), 0);
            check($sformatf("hold%0d res_valid", k), int'(res_valid), 1);
            check($sformatf("hold%0d cond_true", k), int'(cond_true), 1);
            check($sformatf("hold%0d true_cnt", k), int'(true_cnt), exp_cnt);
            step();
        end
        flag_we = 1'b0;
        cond_valid = 1'b0;
        check("hold flags_q", int'(flags_q), 8);
        check("hold cond_true after write", int'(cond_true), 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        issue(4'b1010, 1'b1, 4'hB, 1'b0, "seq lt");
        issue(4'b1010, 1'b1, 4'hC, 1'b1, "seq gt");
        issue(4'b1010, 1'b1, 4'hD, 1'b0, "seq le");

        // Saturation on the 2-bit instance, then clear beats increment
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        exp_cnt = 0; exp_cnt2 = 0;
        check("clr true_cnt", int'(true_cnt), 0);
        for (int k = 0; k < 5; k++) begin
            issue(4'b0000, 1'b1, 4'hE, 1'b1, $sformatf("al%0d", k));
        end
        check("sat true_cnt2", int'(true_cnt2), 3);
        check("nosat true_cnt", int'(true_cnt), 5);
        cnt_clr = 1'b1;
        cond_valid = 1'b1; cond_code = 4'hE;
        step();
        cnt_clr = 1'b0;
        cond_valid = 1'b0;
        exp_cnt = 0; exp_cnt2 = 0;
        check("clr prio res_valid", int'(res_valid), 1);
        check("clr prio true_cnt2", int'(true_cnt2), 0);
        check("clr prio true_cnt", int'(true_cnt), 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Asynchronous reset while holding a result
        flag_we = 1'b1; set_flags(4'b0101);
        cond_valid = 1'b1; cond_code = 4'hE;
        step();
        flag_we = 1'b0; cond_valid = 1'b0;
        check("pre-reset res_valid", int'(res_valid), 1);
        check("pre-reset true_cnt", int'(true_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async res_valid", int'(res_valid), 0);
        check("async flags_q", int'(flags_q), 0);
        check("async cond_true", int'(cond_true), 0);
        check("async true_cnt", int'(true_cnt), 0);
        exp_cnt = 0; exp_cnt2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset cond_ready", int'(cond_ready), 1);
        step();
        check("post-reset res_valid", int'(res_valid), 0);

`ifdef STICKY_OVF_EN
        flag_we = 1'b1; set_flags(4'b1000);
        step();
        check("sticky set", int'(sticky_v), 1);
        set_flags(4'b0000);
        step();
        check("sticky holds", int'(sticky_v), 1);
        flag_we = 1'b0; sticky_clr = 1'b1;
        step();
        check("sticky clr", int'(sticky_v), 0);
        flag_we = 1'b1; set_flags(4'b1000);
        step();
        flag_we = 1'b0; sticky_clr = 1'b0;
        check("sticky set wins", int'(sticky_v), 1);
`else
        flag_we = 1'b1; set_flags(4'b1000);
        step();
        flag_we = 1'b0;
        check("sticky tied", int'(sticky_v), 0);
        check("sticky flags_q", int'(flags_q), 8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
